// File: rtl/rpn_stack_engine_pkg.sv
// Purpose: shared opcode, status and FSM encodings for the RPN stack engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rpn_pkg;

  // Keypad operator tokens
  localparam logic [3:0] OP_CLR  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DUP  = 4'hD;
  localparam logic [3:0] OP_DROP = 4'hE;
  localparam logic [3:0] OP_SWAP = 4'hF;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_OVF = 2'b01,
    ST_UNF = 2'b10,
    ST_ILL = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/rpn_stack_engine_if.sv
// Purpose: command/result bundle between keypad path and the RPN stack engine.
// Latency: n/a (wires only).
// Backpressure: requests are taken only while ready=1; master holds nothing.
// Ports: num_valid/num_data (push), op_valid/op_code (operator), ready, top,
//        depth, status, done.
interface rpn_stack_engine_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             num_valid;
  logic [WIDTH-1:0] num_data;
  logic             op_valid;
  logic [3:0]       op_code;
  logic             ready;
  logic [WIDTH-1:0] top;
  logic [SPW-1:0]   depth;
  logic [1:0]       status;
  logic             done;

  modport master (
    output num_valid, num_data, op_valid, op_code,
    input  ready, top, depth, status, done
  );

  modport slave (
    input  num_valid, num_data, op_valid, op_code,
    output ready, top, depth, status, done
  );
endinterface

// File: rtl/rpn_stack_engine_seq_mul.sv
// Purpose: shift-add multiplier, low WIDTH bits of a*b, one multiplier bit per cycle.
// Latency: start sampled at edge E; done/product valid in the WIDTH-th busy cycle.
// Backpressure: none; start must only be raised while busy=0.
// Ports: clk, reset (async high), start, a, b -> busy, product, done.
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] product,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  assign busy = (cnt != '0);
  // done and product are combinational so the caller can write the result on
  // the same edge that retires the last partial product.
  assign done    = (cnt == CW'(1));
  assign product = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/rpn_stack_engine.sv
// Purpose: DEPTH-entry operand LIFO executing RPN push/ADD/SUB/MUL/DUP/DROP/SWAP/CLR.
// Latency: single-cycle ops complete (done) one cycle after accept; MUL after WIDTH+1.
// Backpressure: ready=1 only in IDLE; requests seen while busy are dropped.
// Ports: clk, reset (async high), bus (slave modport of rpn_stack_engine_if).
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          reset,
  rpn_stack_engine_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp;
  status_t          status_q;
  logic             done_q;
  state_t           state, state_nxt;

  logic             ready, take_num, take_op, mul_start;
  logic [AW-1:0]    i_top, i_sec, i_new;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  // Index helpers; out-of-range values only occur where the op is rejected.
  assign i_top = AW'(sp - SPW'(1));
  assign i_sec = AW'(sp - SPW'(2));
  assign i_new = AW'(sp);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mul_start)                state_nxt = MUL;
        else if (take_num || take_op) state_nxt = EXEC;
      end
      EXEC:    state_nxt = IDLE;
      // !mul_busy guards against ever parking here without a running multiply
      MUL:     if (mul_done || !mul_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / accept decode; a number beats an operator in the same cycle
  always_comb begin
    ready     = (state == IDLE);
    take_num  = ready && bus.num_valid;
    take_op   = ready && bus.op_valid && !bus.num_valid;
    mul_start = take_op && (bus.op_code == OP_MUL) && (sp >= SPW'(2));
  end

  // Stack datapath: every accepted command lands here, errors leave stack/sp alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp       <= '0;
      status_q <= ST_OK;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (take_num) begin
        done_q <= 1'b1;
        if (sp == SP_FULL) begin
          status_q <= ST_OVF;
        end else begin
          stack[i_new] <= bus.num_data;
          sp           <= sp + SPW'(1);
          status_q     <= ST_OK;
        end
      end else if (take_op && !mul_start) begin
        done_q <= 1'b1;
        case (bus.op_code)
          OP_CLR: begin
            sp       <= '0;
            status_q <= ST_OK;
          end
          OP_ADD, OP_SUB: begin
            if (sp < SPW'(2)) begin
              status_q <= ST_UNF;
            end else begin
              stack[i_sec] <= (bus.op_code == OP_ADD) ? stack[i_sec] + stack[i_top]
                                                      : stack[i_sec] - stack[i_top];
              sp       <= sp - SPW'(1);
              status_q <= ST_OK;
            end
          end
          // Only reached with fewer than two operands; valid MULs go to the multiplier
          OP_MUL: status_q <= ST_UNF;
          OP_DUP: begin
            if (sp == '0)           status_q <= ST_UNF;
            else if (sp == SP_FULL) status_q <= ST_OVF;
            else begin
              stack[i_new] <= stack[i_top];
              sp           <= sp + SPW'(1);
              status_q     <= ST_OK;
            end
          end
          OP_DROP: begin
            if (sp == '0) status_q <= ST_UNF;
            else begin
              sp       <= sp - SPW'(1);
              status_q <= ST_OK;
            end
          end
          OP_SWAP: begin
            if (sp < SPW'(2)) status_q <= ST_UNF;
            else begin
              stack[i_top] <= stack[i_sec];
              stack[i_sec] <= stack[i_top];
              status_q     <= ST_OK;
            end
          end
          default: status_q <= ST_ILL;
        endcase
      end else if (state == MUL && mul_done) begin
        stack[i_sec] <= mul_prod;
        sp           <= sp - SPW'(1);
        status_q     <= ST_OK;
        done_q       <= 1'b1;
      end
    end
  end

  // Operands are latched inside the multiplier at accept
  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (stack[i_top]),
    .b       (stack[i_sec]),
    .busy    (mul_busy),
    .product (mul_prod),
    .done    (mul_done)
  );

  assign bus.ready  = ready;
  assign bus.top    = (sp == '0) ? '0 : stack[i_top];
  assign bus.depth  = sp;
  assign bus.status = status_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Purpose: self-checking bench for rpn_stack_engine against a queue-based RPN model.
// Latency: checks done timing (1 cycle, or WIDTH+1 for MUL) after each accept.
// Backpressure: drives requests only when ready, injects ignored noise while busy.
module tb_rpn_stack_engine;
  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rpn_stack_engine_if #(.WIDTH(W), .DEPTH(D)) bus ();

  rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [1:0]  mst;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RPN rules on a queue, back of queue = top of stack
  task automatic model_apply(input bit is_num, input logic [31:0] val,
                             input logic [3:0] code, output int lat);
    logic [31:0] a, b, r;
    lat = 1;
    if (is_num) begin
      if (mq.size() == D) mst = 2'b01;
      else begin mq.push_back(val); mst = 2'b00; end
    end else begin
      case (code)
        4'h0: begin mq.delete(); mst = 2'b00; end
        4'hA, 4'hB, 4'hC: begin
          if (mq.size() < 2) mst = 2'b10;
          else begin
            a = mq.pop_back();
            b = mq.pop_back();
            if (code == 4'hA)      r = b + a;
            else if (code == 4'hB) r = b - a;
            else begin r = b * a; lat = W + 1; end
            mq.push_back(r);
            mst = 2'b00;
          end
        end
        4'hD: begin
          if (mq.size() == 0)      mst = 2'b10;
          else if (mq.size() == D) mst = 2'b01;
          else begin mq.push_back(mq[$]); mst = 2'b00; end
        end
        4'hE: begin
          if (mq.size() == 0) mst = 2'b10;
          else begin a = mq.pop_back(); mst = 2'b00; end
        end
        4'hF: begin
          if (mq.size() < 2) mst = 2'b10;
          else begin
            a = mq.pop_back();
            b = mq.pop_back();
            mq.push_back(a);
            mq.push_back(b);
            mst = 2'b00;
          end
        end
        default: mst = 2'b11;
      endcase
    end
  endtask

  function automatic logic [31:0] model_top();
    if (mq.size() == 0) return 32'h0;
    return mq[$];
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, " top"},    bus.top,                     model_top());
    check_val({tag, " depth"},  32'(bus.depth),              32'(mq.size()));
    check_val({tag, " status"}, 32'(bus.status),             32'(mst));
  endtask

  // One command: present at a negedge, accepted at the next posedge,
  // then watch for done with a bounded wait.
  task automatic run_cmd(input bit is_num, input logic [31:0] val, input logic [3:0] code,
                         input bit both, input bit noise, input string tag);
    int lat_exp;
    int lat;
    bit seen;
    @(negedge clk);
    check_val({tag, " ready"}, 32'(bus.ready), 32'd1);
    bus.num_valid = is_num || both;
    bus.num_data  = val;
    bus.op_valid  = !is_num || both;
    bus.op_code   = code;
    model_apply(is_num || both, val, code, lat_exp);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_val({tag, " busy"}, 32'(bus.ready), 32'd0);
      seen = bus.done;
      if (noise && !seen) begin
        bus.num_valid = 1'($urandom_range(0, 1));
        bus.num_data  = $urandom;
        bus.op_valid  = 1'($urandom_range(0, 1));
        bus.op_code   = 4'($urandom_range(0, 15));
      end else begin
        bus.num_valid = 1'b0;
        bus.op_valid  = 1'b0;
      end
    end
    check_val({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check_state(tag);
  endtask

  task automatic push(input logic [31:0] v, input string tag);
    run_cmd(1'b1, v, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic op(input logic [3:0] c, input string tag);
    run_cmd(1'b0, 32'h0, c, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    bus.num_valid = 1'b0;
    bus.num_data  = '0;
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    mst = 2'b00;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst ready",  32'(bus.ready),  32'd1);
    check_val("rst done",   32'(bus.done),   32'd0);
    check_state("rst");
    reset = 1'b0;

    // Add / subtract
    push(32'd5, "t1 p5");
    push(32'd7, "t1 p7");
    op(4'hA, "t1 add");
    op(4'h0, "t2 clr");
    push(32'd3, "t2 p3");
    push(32'd10, "t2 p10");
    op(4'hB, "t2 sub");

    // Multiply, including wrap-around
    op(4'h0, "t3 clr");
    push(32'd6, "t3 p6");
    push(32'd7, "t3 p7");
    op(4'hC, "t3 mul");
    push(32'h10000, "t3 pa");
    push(32'h10000, "t3 pb");
    op(4'hC, "t3 mulwrap");

    // Overflow
    op(4'h0, "t4 clr");
    for (int i = 0; i < D; i++) push(32'(100 + i), "t4 fill");
    push(32'hDEAD, "t4 ovf");
    op(4'hD, "t4 dupovf");

    // Underflow and illegal on empty stack
    op(4'h0, "t5 clr");
    op(4'hA, "t5 addunf");
    op(4'hE, "t5 dropunf");
    op(4'h5, "t5 ill");
    op(4'hC, "t5 mulunf");

    // Number and operator together: only the push happens
    push(32'd1, "t6 p1");
    run_cmd(1'b1, 32'h55, 4'hA, 1'b1, 1'b0, "t6 both");

    // Randomized commands with noise while busy
    op(4'h0, "rnd clr");
    for (int n = 0; n < 300; n++) begin
      bit is_num;
      logic [31:0] v;
      is_num = ($urandom_range(0, 99) < 50);
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_cmd(is_num, v, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), "rnd");
    end

    // Reset in the middle of a multiply
    op(4'h0, "t7 clr");
    push(32'd9, "t7 p9");
    push(32'd11, "t7 p11");
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'hC;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check_val("t7 mulbusy", 32'(bus.ready), 32'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    mq.delete();
    mst = 2'b00;
    check_val("t7 rst ready", 32'(bus.ready), 32'd1);
    check_val("t7 rst done",  32'(bus.done),  32'd0);
    check_state("t7 rst");
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_val("t7 nodone", 32'(done_cnt), 32'd0);
    check_state("t7 after");
    push(32'h1234, "t7 push");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
